// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr block.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   chan_w(n)            : channel-index width for an n-channel mux
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n channels; a 1-channel case still needs one bit.
  function automatic int chan_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: NCH packed input streams and one output
// stream with its source-channel tag.
//   in_data  [NCH*DW] channel i at [i*DW +: DW]
//   in_valid [NCH]    per-channel valid
//   in_ready [NCH]    per-channel ready from the mux
//   out_data [DW]     registered output data
//   out_valid         registered output valid
//   out_ready         downstream ready
//   out_ch   [SELW]   channel that supplied out_data
// Modports: slave = the mux's view, master = the surrounding logic's view.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  localparam int SELW = chan_w(NCH);

  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SELW-1:0]   out_ch;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter with a registered search pointer.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   req        : per-channel requests
//   advance    : a grant from this arbiter was consumed this cycle
//   adv_idx    : index of the consumed channel
//   grant      : one-hot (or zero) grant to the first requester at or
//                after the pointer, wrapping NCH-1 -> 0
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = chan_w(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  input  logic [SELW-1:0] adv_idx,
  output logic [NCH-1:0]  grant
);

  logic [SELW-1:0] ptr_reg;
  logic [SELW-1:0] ptr_next;
  logic            found;
  int              idx;

  // Walk NCH positions starting at the pointer; the pointer is always
  // below NCH so a single subtraction implements the modulo wrap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Explicit wrap so non-power-of-two channel counts never reach NCH.
  always_comb begin
    ptr_next = ptr_reg;
    if (advance) begin
      ptr_next = (adv_idx == SELW'(NCH - 1)) ? '0 : adv_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Fixed mode forwards channel sel; round-robin mode rotates fairly among
// valid channels. One cycle latency, one word per cycle throughput.
//   clk, rst_n : clock, synchronous active-low reset
//   mode       : MODE_FIXED or MODE_RR
//   sel        : channel used in fixed mode (values >= NCH grant nothing)
//   bus        : stream_mux_rr_if.slave (inputs, output, out_ch tag)
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int DW   = 8,
  localparam int SELW = chan_w(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  stream_mux_rr_if.slave  bus
);

  logic [NCH-1:0]  fix_grant;
  logic [NCH-1:0]  rr_grant;
  logic [NCH-1:0]  grant;
  logic            load_en;
  logic            xfer;
  logic [SELW-1:0] gnt_idx;
  logic [DW-1:0]   gnt_data;

  logic            out_valid_reg, out_valid_next;
  logic [DW-1:0]   out_data_reg,  out_data_next;
  logic [SELW-1:0] out_ch_reg,    out_ch_next;

  // Output register is free, or its word leaves this cycle.
  assign load_en = !out_valid_reg || bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_fix
      assign fix_grant[gi] = bus.in_valid[gi] && (sel == SELW'(gi));
    end
  endgenerate

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.in_valid),
    .advance (xfer && (mode == MODE_RR)),
    .adv_idx (gnt_idx),
    .grant   (rr_grant)
  );

  assign grant = (mode == MODE_RR) ? rr_grant : fix_grant;

  // Ready is held low during reset so no producer sees an acceptance that
  // the reset would silently drop.
  assign bus.in_ready = grant & {NCH{load_en && rst_n}};
  assign xfer         = |bus.in_ready;

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        gnt_idx  = SELW'(i);
        gnt_data = bus.in_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    if (load_en) begin
      out_valid_next = xfer;
      if (xfer) begin
        out_data_next = gnt_data;
        out_ch_next   = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer; successor to the fixed 4:1 single-bit combinational mux.
- Selects one of NCH valid/ready input streams onto a single registered output stream.
- Two modes: fixed select (external sel) and round-robin arbitration among valid inputs.
- Sits between producer channels and a shared downstream consumer; one cycle latency, full throughput.

Parameters:
- NCH, 4, number of input channels (>=2; need not be a power of two)
- DW, 8, data width per channel in bits
- SELW, $clog2(NCH), select/channel-index width (derived localparam, not overridable)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active low, sampled on rising edge of clk
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- in_data  input  NCH*DW  packed channel data; channel i at [i*DW +: DW]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- out_data  output  DW  registered output data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready
- out_ch  output  SELW  registered index of channel that supplied out_data

Behaviour:
- Reset: one clk edge with rst_n=0 sets out_valid=0, out_data=0, out_ch=0, rr pointer=0. Reset overrides everything, including a transfer pending in the same cycle; any accepted-but-undelivered word is dropped.
- load_en = !out_valid || out_ready (output register free or draining this cycle).
- Grant is one-hot or zero. in_ready[i] = load_en && grant[i]. An input transfer occurs when in_valid[i] && in_ready[i].
- On an input transfer: next cycle out_valid=1, out_data=in_data[i], out_ch=i. Latency is exactly 1 cycle.
- Output transfer: out_valid && out_ready. If no input transfer occurs in the same cycle, out_valid clears next cycle.
- Back-to-back transfers: 1 word/cycle while out_ready=1.
- While out_valid=1 and out_ready=0: out_data and out_ch are held stable; all in_ready=0.
- Fixed mode (mode=0):
  - grant[sel]=1 only if in_valid[sel]=1.
  - sel >= NCH (non-power-of-two NCH) gives no grant.
  - sel is evaluated combinationally each cycle; only its value at the load edge matters.
- Round-robin mode (mode=1):
  - Search in_valid starting at the pointer index, wrapping NCH-1 -> 0.
  - Grant the first valid channel found.
  - On an input transfer from channel g, pointer <= (g+1) mod NCH, with wrap from NCH-1 to 0.
  - Pointer is unchanged when no transfer occurs, including while stalled by out_ready=0.
- Fixed-mode transfers do not update the pointer. Switching mode takes effect on the next load decision; no flush is needed.
- in_valid withdrawn before it is accepted: nothing is loaded (the block does not require valid to be held).
- No valid inputs: no grant, out_valid falls after the current output word drains.
- Simultaneous output drain and new load: out_valid stays 1 and the new data replaces the old on the same edge.

Decomposition:
- Package stream_mux_pkg holds:
  - mode encodings MODE_FIXED=1'b0 and MODE_RR=1'b1
  - a function returning the channel-index width for a given channel count
- One sub-module, rr_arbiter (params NCH), containing the pointer register and rotate-priority grant logic.
  - Inputs: clk, rst_n, req[NCH], advance, adv_idx.
  - Output: one-hot grant[NCH].
  - stream_mux_rr instantiates it and muxes its grant against the fixed-select grant by mode.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout reset.
- Fixed mode: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> one cycle later out_valid=1, out_data=8'hA5, out_ch=2. With sel=1 and in_valid=4'b0100 -> no transfer, out_valid returns to 0.
- Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1, channel i data=8'h10+i -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles; pointer wraps 3->0.
- Sparse round-robin: mode=1, in_valid=4'b1010 -> out_ch alternates 1,3,1,3; sel ignored.
- Backpressure: out_valid=1 carrying 8'h11, out_ready=0 for 3 cycles -> out_data held at 8'h11, in_ready=0, pointer unchanged. Then out_ready=1 -> next word loads on the same edge with no bubble.
- NCH=3 build: mode=0, sel=3 -> no grant, out_valid stays 0. Mode=1 with all valid -> out_ch 0,1,2,0.
